// File: rtl/uart_rx_frame_checker_if.sv
// Serial line, frame configuration and status bundle between the RX pad
// synchronizer side and the frame checker.
interface uart_rx_frame_checker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);
  logic                  RX_IN;
  logic [PRESC_W-1:0]    Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Par_Err;
  logic                  Stp_Err;
  logic                  Busy;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, Data_Valid, Par_Err, Stp_Err, Busy
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, Data_Valid, Par_Err, Stp_Err, Busy
  );
endinterface

// File: rtl/uart_rx_frame_checker.sv
// UART receive frame checker: oversampled start/data/parity/stop recovery
// with 3-sample majority vote, LSB-first deserialization, parity and stop
// checking, and one-cycle registered status pulses.
module uart_rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input logic                     CLK,
  input logic                     RST,
  uart_rx_frame_checker_if.slave  bus
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state;
  logic [PRESC_W-1:0]    presc;
  logic [PRESC_W-1:0]    presc_sel;
  logic [PRESC_W-1:0]    edge_cnt;
  logic [PRESC_W-1:0]    half;
  logic [BCW-1:0]        bit_cnt;
  logic                  par_en;
  logic                  par_typ;
  logic                  par_bad;
  logic [2:0]            samp;
  logic [DATA_WIDTH-1:0] data;
  logic                  maj;
  logic                  bit_end;
  logic                  samp_tick;
  logic                  exp_par;

  // Map the requested oversample ratio onto the supported set; anything else runs at 8.
  always_comb begin
    presc_sel = PRESC_W'(8);
    if (bus.Prescale == PRESC_W'(16))      presc_sel = PRESC_W'(16);
    else if (bus.Prescale == PRESC_W'(32)) presc_sel = PRESC_W'(32);
  end

  // Bit timing decode and majority of the three mid-bit samples.
  always_comb begin
    half      = presc >> 1;
    bit_end   = (edge_cnt == presc - PRESC_W'(1));
    samp_tick = (edge_cnt == half - PRESC_W'(1)) || (edge_cnt == half) ||
                (edge_cnt == half + PRESC_W'(1));
    maj       = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    exp_par   = par_typ ? ~^data : ^data;
  end

  assign bus.Busy = (state != IDLE);

  // Frame FSM: tick 0 of the start bit is consumed in IDLE, so the counter
  // resumes at 1; every bit decision is taken on its last tick.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      presc          <= '0;
      edge_cnt       <= '0;
      bit_cnt        <= '0;
      par_en         <= 1'b0;
      par_typ        <= 1'b0;
      par_bad        <= 1'b0;
      samp           <= '0;
      data           <= '0;
      bus.P_DATA     <= '0;
      bus.Data_Valid <= 1'b0;
      bus.Par_Err    <= 1'b0;
      bus.Stp_Err    <= 1'b0;
    end else begin
      bus.Data_Valid <= 1'b0;
      bus.Par_Err    <= 1'b0;
      bus.Stp_Err    <= 1'b0;
      if (state != IDLE) begin
        edge_cnt <= bit_end ? '0 : edge_cnt + PRESC_W'(1);
        if (samp_tick) samp <= {samp[1:0], bus.RX_IN};
      end
      case (state)
        IDLE: begin
          if (!bus.RX_IN) begin
            state    <= START;
            presc    <= presc_sel;
            par_en   <= bus.PAR_EN;
            par_typ  <= bus.PAR_TYP;
            edge_cnt <= PRESC_W'(1);
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
          end
        end
        START: begin
          // A high majority means the low level was a glitch, not a start bit.
          if (bit_end) state <= maj ? IDLE : DATA;
        end
        DATA: begin
          if (bit_end) begin
            data <= {maj, data[DATA_WIDTH-1:1]};
            if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= par_en ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            par_bad <= (maj != exp_par);
            state   <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            state          <= IDLE;
            bus.Data_Valid <= !par_bad && maj;
            bus.Par_Err    <= par_bad;
            bus.Stp_Err    <= !maj;
            if (!par_bad && maj) bus.P_DATA <= data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
